// File: rtl/demux_dispatch_1to4.sv
// Buffered 1-to-4 valid/ready dispatcher: each output channel owns a 2-entry FIFO,
// destination chosen by sel or by an internal round-robin pointer (RR_MODE=1).
module demux_dispatch_1to4 #(
   parameter int DATA_W  = 8,
   parameter int RR_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [1:0]            sel,
   output logic                  in_ready,
   output logic [3:0]            out_valid,
   output logic [4*DATA_W-1:0]   out_data,
   input  logic [3:0]            out_ready,
   output logic [1:0]            rr_ptr
);

   logic [3:0][1:0][DATA_W-1:0] mem_q;
   logic [3:0]                  wptr_q, wptr_d;
   logic [3:0]                  rptr_q, rptr_d;
   logic [3:0][1:0]             cnt_q, cnt_d;
   logic [1:0]                  rr_q, rr_d;
   logic [1:0]                  dst;
   logic [3:0]                  full;
   logic [3:0]                  push;
   logic [3:0]                  pop;
   logic                        accept;

   always_comb begin
      dst      = (RR_MODE != 0) ? rr_q : sel;
      full     = '0;
      out_valid = '0;
      out_data = '0;
      for (int k = 0; k < 4; k++) begin
         full[k]      = (cnt_q[k] == 2'd2);
         out_valid[k] = (cnt_q[k] != 2'd0);
         // Empty channels present zero rather than stale storage.
         if (out_valid[k])
            out_data[k*DATA_W +: DATA_W] = mem_q[k][rptr_q[k]];
      end
      in_ready = ~full[dst];
      accept   = in_valid & in_ready;
      push     = accept ? (4'b0001 << dst) : 4'b0000;
      pop      = out_valid & out_ready;
      rr_ptr   = rr_q;
   end

   always_comb begin
      wptr_d = wptr_q ^ push;
      rptr_d = rptr_q ^ pop;
      cnt_d  = cnt_q;
      for (int k = 0; k < 4; k++)
         cnt_d[k] = cnt_q[k] + 2'(push[k]) - 2'(pop[k]);
      // The pointer holds on a stall so channel order is never skipped.
      rr_d = ((RR_MODE != 0) && accept) ? rr_q + 2'd1 : rr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         rr_q   <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         rr_q   <= rr_d;
      end
   end

   // Storage needs no reset: reads are gated by the channel count.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (push[k])
            mem_q[k][wptr_q[k]] <= in_data;
   end

endmodule

// File: tb/tb_demux_dispatch_1to4.sv
// Bench for demux_dispatch_1to4: one instance with sel routing, one in round-robin mode,
// checked against queue-based channel models plus directed vector tables.
module tb_demux_dispatch_1to4;

   logic        clk;
   logic        rst;
   logic        vld   [2];
   logic [1:0]  sel   [2];
   logic [7:0]  dat   [2];
   logic [3:0]  ordy  [2];
   logic        ir    [2];
   logic [3:0]  ov    [2];
   logic [31:0] od    [2];
   logic [1:0]  rp    [2];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef logic [7:0] bq_t[$];
   bq_t        mq [2][4];
   logic [1:0] rr [2];

   demux_dispatch_1to4 #(.DATA_W(8), .RR_MODE(0)) u_sel (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .sel(sel[0]),
      .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
      .rr_ptr(rp[0]));

   demux_dispatch_1to4 #(.DATA_W(8), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .sel(sel[1]),
      .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
      .rr_ptr(rp[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         rr[m] = 2'd0;
         for (int k = 0; k < 4; k++) mq[m][k].delete();
      end
   endtask

   // Compare both instances with the queue model on the falling edge.
   task automatic sample();
      logic [1:0]  d;
      logic [3:0]  eov;
      logic [31:0] eod;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         d   = (m == 1) ? rr[m] : sel[m];
         eov = '0;
         eod = '0;
         for (int k = 0; k < 4; k++)
            if (mq[m][k].size() > 0) begin
               eov[k] = 1'b1;
               eod[k*8 +: 8] = mq[m][k][0];
            end
         chk((m == 1) ? "rr in_ready" : "sel in_ready", 32'(ir[m]), 32'(mq[m][d].size() < 2));
         chk((m == 1) ? "rr out_valid" : "sel out_valid", 32'(ov[m]), 32'(eov));
         chk((m == 1) ? "rr out_data" : "sel out_data", od[m], eod);
         chk((m == 1) ? "rr rr_ptr" : "sel rr_ptr", 32'(rp[m]), 32'((m == 1) ? rr[m] : 2'd0));
      end
   endtask

   // Take the rising edge and apply the same transfers to the model.
   task automatic advance();
      logic [1:0] d;
      logic       acc;
      @(posedge clk);
      if (rst) model_clear();
      else begin
         for (int m = 0; m < 2; m++) begin
            d   = (m == 1) ? rr[m] : sel[m];
            acc = vld[m] && (mq[m][d].size() < 2);
            for (int k = 0; k < 4; k++)
               if (ordy[m][k] && mq[m][k].size() > 0) void'(mq[m][k].pop_front());
            if (acc) begin
               mq[m][d].push_back(dat[m]);
               if (m == 1) rr[m] = rr[m] + 2'd1;
            end
         end
      end
      #1;
   endtask

   task automatic drain();
      vld[0] = 1'b0; vld[1] = 1'b0;
      ordy[0] = 4'hF; ordy[1] = 4'hF;
      for (int i = 0; i < 3; i++) begin sample(); advance(); end
   endtask

   typedef struct {
      logic        v;
      logic [1:0]  s;
      logic [7:0]  d;
      logic [3:0]  r;
      logic        eir;
      logic [3:0]  eov;
      logic [31:0] eod;
   } vec_t;

   vec_t tbl [11];
   bq_t  recv [4];
   int   w, accepted;
   logic hold [2];

   initial begin
      tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'h0, 1'b1, 4'b0000, 32'h0000_0000};
      tbl[1]  = '{1'b0, 2'd2, 8'h00, 4'h0, 1'b1, 4'b0100, 32'h00A5_0000};
      tbl[2]  = '{1'b0, 2'd2, 8'h00, 4'h4, 1'b1, 4'b0100, 32'h00A5_0000};
      tbl[3]  = '{1'b1, 2'd1, 8'h11, 4'h0, 1'b1, 4'b0000, 32'h0000_0000};
      tbl[4]  = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b1, 4'b0010, 32'h0000_1100};
      tbl[5]  = '{1'b1, 2'd1, 8'h33, 4'h0, 1'b0, 4'b0010, 32'h0000_1100};
      tbl[6]  = '{1'b1, 2'd1, 8'h33, 4'h2, 1'b0, 4'b0010, 32'h0000_1100};
      tbl[7]  = '{1'b1, 2'd1, 8'h33, 4'h0, 1'b1, 4'b0010, 32'h0000_2200};
      tbl[8]  = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b0, 4'b0010, 32'h0000_2200};
      tbl[9]  = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b1, 4'b0010, 32'h0000_3300};
      tbl[10] = '{1'b0, 2'd1, 8'h00, 4'h0, 1'b1, 4'b0000, 32'h0000_0000};

      for (int m = 0; m < 2; m++) begin
         vld[m] = 1'b0; sel[m] = 2'd0; dat[m] = 8'h00; ordy[m] = 4'h0; hold[m] = 1'b0;
      end
      model_clear();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(ov[0]), 32'h0);
      chk("reset out_data", od[0], 32'h0);
      chk("reset in_ready", 32'(ir[0]), 32'h1);
      chk("reset rr_ptr", 32'(rp[1]), 32'h0);
      rst = 1'b0;

      // Directed single-word delivery and channel-1 back-pressure.
      for (int i = 0; i < 11; i++) begin
         vld[0] = tbl[i].v; sel[0] = tbl[i].s; dat[0] = tbl[i].d; ordy[0] = tbl[i].r;
         sample();
         chk($sformatf("tbl%0d in_ready", i), 32'(ir[0]), 32'(tbl[i].eir));
         chk($sformatf("tbl%0d out_valid", i), 32'(ov[0]), 32'(tbl[i].eov));
         chk($sformatf("tbl%0d out_data", i), od[0], tbl[i].eod);
         advance();
      end

      // Channel 3 at count 1: push and pop in the same cycle.
      vld[0] = 1'b1; sel[0] = 2'd3; dat[0] = 8'hAA; ordy[0] = 4'h0;
      sample(); advance();
      dat[0] = 8'hBB; ordy[0] = 4'h8;
      sample();
      chk("pp head before", 32'(od[0][31:24]), 32'hAA);
      advance();
      vld[0] = 1'b0; ordy[0] = 4'h0;
      sample();
      chk("pp out_valid", 32'(ov[0]), 32'h8);
      chk("pp head after", 32'(od[0][31:24]), 32'hBB);
      advance();
      drain();

      // Round-robin distribution with every consumer ready.
      for (int k = 0; k < 4; k++) recv[k].delete();
      w = 0;
      ordy[1] = 4'hF;
      for (int c = 0; c < 12; c++) begin
         vld[1] = (w < 8); dat[1] = 8'(w); sel[1] = 2'($urandom_range(0, 3));
         sample();
         for (int k = 0; k < 4; k++)
            if (ov[1][k] && ordy[1][k]) recv[k].push_back(od[1][k*8 +: 8]);
         accepted = int'(vld[1] && ir[1]);
         advance();
         w += accepted;
      end
      chk("rr words sent", 32'(w), 32'd8);
      chk("rr ptr wrapped", 32'(rp[1]), 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr ch%0d count", k), 32'(recv[k].size()), 32'd2);
         if (recv[k].size() == 2) begin
            chk($sformatf("rr ch%0d first", k), 32'(recv[k][0]), 32'(k));
            chk($sformatf("rr ch%0d second", k), 32'(recv[k][1]), 32'(k + 4));
         end
      end

      // Round-robin stall behind a blocked channel 0.
      ordy[1] = 4'b1110; accepted = 0; w = 0;
      for (int c = 0; c < 40 && w == 0; c++) begin
         vld[1] = 1'b1; dat[1] = 8'(8'h40 + accepted);
         sample();
         if (!ir[1]) w = 1;
         else begin advance(); accepted++; end
      end
      chk("stall seen", 32'(w), 32'd1);
      chk("stall after words", 32'(accepted), 32'd8);
      chk("stall rr_ptr", 32'(rp[1]), 32'h0);
      advance();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("stall holds", 32'(ir[1]), 32'h0);
         advance();
      end
      ordy[1] = 4'hF;
      sample();
      chk("stall release edge", 32'(ir[1]), 32'h0);
      advance();
      sample();
      chk("stall cleared", 32'(ir[1]), 32'h1);
      advance();
      drain();

      // Asynchronous reset with queued data in both instances.
      ordy[0] = 4'h0; ordy[1] = 4'h0;
      vld[0] = 1'b1; vld[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel[0] = (i < 2) ? 2'd0 : 2'd2; dat[0] = 8'(8'hC0 + i); dat[1] = 8'(8'hD0 + i);
         sample(); advance();
      end
      vld[0] = 1'b0; vld[1] = 1'b0; sel[0] = 2'd0;
      sample();
      chk("pre-reset full ch0", 32'(ir[0]), 32'h0);
      #1;
      rst = 1'b1;
      model_clear();
      #1;
      chk("async out_valid", 32'(ov[0]), 32'h0);
      chk("async out_data", od[0], 32'h0);
      chk("async rr out_valid", 32'(ov[1]), 32'h0);
      chk("async rr_ptr", 32'(rp[1]), 32'h0);
      advance();
      rst = 1'b0;
      vld[0] = 1'b1; sel[0] = 2'd0; dat[0] = 8'h5A;
      sample();
      chk("post-reset in_ready", 32'(ir[0]), 32'h1);
      advance();
      vld[0] = 1'b0;
      sample();
      chk("post-reset word", od[0], 32'h0000_005A);
      advance();
      drain();

      // Random traffic on both instances; the source holds a refused word.
      for (int c = 0; c < 3000; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!hold[m]) begin
               vld[m] = ($urandom_range(0, 3) != 0);
               sel[m] = 2'($urandom_range(0, 3));
               dat[m] = 8'($urandom);
            end
            ordy[m] = 4'($urandom);
         end
         sample();
         for (int m = 0; m < 2; m++) hold[m] = vld[m] && !ir[m];
         advance();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
